uart_rx_sequencer: RTL and testbench

Receive-side bit sequencer for the UART 16750. It turns an oversampled, already-synchronised serial line into framed characters with parity, framing and break status. Internally it drives a sample counter and a bit counter with clear, load and enable. It sits between the baud generator (which supplies the oversample strobe) and the receive FIFO (which consumes each finished character).

---
 rtl/uart_rx_sequencer.sv | 177 +++++++++++++++++
 tb/tb_uart_rx_sequencer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_sequencer.sv
// Receive-side bit sequencer: frames an oversampled serial line into characters and
// reports parity, framing and break status with a one-cycle completion pulse.
module uart_rx_sequencer #(
  parameter int unsigned OSR = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RXCLK,
  input  logic       CLEAR,
  input  logic       RXD,
  input  logic [1:0] WLS,
  input  logic       PEN,
  input  logic       EPS,
  input  logic       SP,
  output logic [7:0] DOUT,
  output logic       PE,
  output logic       FE,
  output logic       BI,
  output logic       RXFINISHED
);

  localparam int unsigned SW = $clog2(OSR);
  localparam logic [SW-1:0] SCNT_MID  = SW'(OSR / 2 - 1);
  localparam logic [SW-1:0] SCNT_LAST = SW'(OSR - 1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] PAR   = 3'd3;
  localparam logic [2:0] STOP  = 3'd4;
  localparam logic [2:0] MWAIT = 3'd5;

  logic [2:0]    state_q, state_d;
  logic [SW-1:0] scnt_q, scnt_d;
  logic [2:0]    bcnt_q, bcnt_d;
  logic [7:0]    data_q, data_d;
  logic          par_q, par_d;
  logic [1:0]    wls_q, wls_d;
  logic          pen_q, pen_d;
  logic          eps_q, eps_d;
  logic          sp_q, sp_d;
  logic [7:0]    dout_q, dout_d;
  logic          pe_q, pe_d;
  logic          fe_q, fe_d;
  logic          bi_q, bi_d;
  logic          fin_q, fin_d;
  logic          par_xor;
  logic          mid_bit;

  assign par_xor = (^data_q) ^ par_q;
  assign mid_bit = (scnt_q == SCNT_LAST);

  always_comb begin
    state_d = state_q;
    scnt_d  = scnt_q;
    bcnt_d  = bcnt_q;
    data_d  = data_q;
    par_d   = par_q;
    wls_d   = wls_q;
    pen_d   = pen_q;
    eps_d   = eps_q;
    sp_d    = sp_q;
    dout_d  = dout_q;
    pe_d    = pe_q;
    fe_d    = fe_q;
    bi_d    = bi_q;
    fin_d   = 1'b0;
    if (CLEAR) begin
      state_d = IDLE;
      scnt_d  = '0;
      bcnt_d  = '0;
    end else if (RXCLK) begin
      case (state_q)
        IDLE: begin
          if (!RXD) begin
            state_d = START;
            scnt_d  = '0;
          end
        end
        START: begin
          if (scnt_q == SCNT_MID) begin
            if (RXD) begin
              state_d = IDLE;
            end else begin
              // Start bit confirmed: freeze the frame format for this character.
              state_d = DATA;
              scnt_d  = '0;
              bcnt_d  = '0;
              data_d  = '0;
              par_d   = 1'b0;
              wls_d   = WLS;
              pen_d   = PEN;
              eps_d   = EPS;
              sp_d    = SP;
            end
          end else begin
            scnt_d = scnt_q + SW'(1);
          end
        end
        DATA: begin
          scnt_d = scnt_q + SW'(1);
          if (mid_bit) begin
            data_d[bcnt_q] = RXD;
            if (bcnt_q == {1'b1, wls_q}) begin
              state_d = pen_q ? PAR : STOP;
            end else begin
              bcnt_d = bcnt_q + 3'd1;
            end
          end
        end
        PAR: begin
          scnt_d = scnt_q + SW'(1);
          if (mid_bit) begin
            par_d   = RXD;
            state_d = STOP;
          end
        end
        STOP: begin
          scnt_d = scnt_q + SW'(1);
          if (mid_bit) begin
            dout_d  = data_q;
            pe_d    = pen_q & (sp_q ? (par_q ^ ~eps_q) : (par_xor ^ ~eps_q));
            fe_d    = ~RXD;
            bi_d    = (data_q == 8'h00) & ~par_q & ~RXD;
            fin_d   = 1'b1;
            state_d = RXD ? IDLE : MWAIT;
          end
        end
        MWAIT: begin
          if (RXD) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      scnt_q  <= '0;
      bcnt_q  <= '0;
      data_q  <= '0;
      par_q   <= 1'b0;
      wls_q   <= '0;
      pen_q   <= 1'b0;
      eps_q   <= 1'b0;
      sp_q    <= 1'b0;
      dout_q  <= '0;
      pe_q    <= 1'b0;
      fe_q    <= 1'b0;
      bi_q    <= 1'b0;
      fin_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      scnt_q  <= scnt_d;
      bcnt_q  <= bcnt_d;
      data_q  <= data_d;
      par_q   <= par_d;
      wls_q   <= wls_d;
      pen_q   <= pen_d;
      eps_q   <= eps_d;
      sp_q    <= sp_d;
      dout_q  <= dout_d;
      pe_q    <= pe_d;
      fe_q    <= fe_d;
      bi_q    <= bi_d;
      fin_q   <= fin_d;
    end
  end

  assign DOUT       = dout_q;
  assign PE         = pe_q;
  assign FE         = fe_q;
  assign BI         = bi_q;
  assign RXFINISHED = fin_q;

endmodule

// File: tb/tb_uart_rx_sequencer.sv
// Directed bench for uart_rx_sequencer: serial frames driven bit by bit, results checked
// with immediate assertions against hand-computed values.
module tb_uart_rx_sequencer;

  localparam int unsigned OSR = 16;

  logic       CLK = 1'b0;
  logic       RST;
  logic       RXCLK = 1'b1;
  logic       CLEAR;
  logic       RXD;
  logic [1:0] WLS;
  logic       PEN;
  logic       EPS;
  logic       SP;
  logic [7:0] DOUT;
  logic       PE;
  logic       FE;
  logic       BI;
  logic       RXFINISHED;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int fin_count = 0;
  int fin_cyc = 0;
  int start_cyc = 0;
  int f0 = 0;
  int rxdiv = 1;
  int ph = 0;

  uart_rx_sequencer #(.OSR(OSR)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .RXCLK      (RXCLK),
    .CLEAR      (CLEAR),
    .RXD        (RXD),
    .WLS        (WLS),
    .PEN        (PEN),
    .EPS        (EPS),
    .SP         (SP),
    .DOUT       (DOUT),
    .PE         (PE),
    .FE         (FE),
    .BI         (BI),
    .RXFINISHED (RXFINISHED)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Oversample strobe: every cycle when rxdiv=1, otherwise one cycle in rxdiv.
  always @(posedge CLK) begin
    #1;
    ph = (ph + 1) % rxdiv;
    RXCLK = (ph == 0);
  end

  always @(negedge CLK) begin
    if (RXFINISHED === 1'b1) begin
      fin_count = fin_count + 1;
      fin_cyc = cyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input logic b);
    RXD = b;
    repeat (OSR * rxdiv) @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    RXD = 1'b1;
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input int nb, input logic pen_bit,
                            input logic par, input logic stop);
    start_cyc = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < nb; i++) drive_bit(d[i]);
    if (pen_bit) drive_bit(par);
    drive_bit(stop);
    RXD = 1'b1;
  endtask

  initial begin
    RST = 1'b1; CLEAR = 1'b0; RXD = 1'b1;
    WLS = 2'b11; PEN = 1'b0; EPS = 1'b0; SP = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_dout", 32'(DOUT), 32'h00);
    chk("rst_flags", 32'({PE, FE, BI, RXFINISHED}), 32'h0);
    RST = 1'b0;
    idle(5);

    // 8N1 0xA5, with latency from start edge
    f0 = fin_count;
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1);
    idle(8);
    chk("a5_fin", 32'(fin_count - f0), 32'd1);
    chk("a5_lat", 32'(fin_cyc - start_cyc), 32'd153);
    chk("a5_dout", 32'(DOUT), 32'hA5);
    chk("a5_flags", 32'({PE, FE, BI}), 32'h0);

    // 7E1 0x35: parity 1 is wrong, parity 0 is right
    WLS = 2'b10; PEN = 1'b1; EPS = 1'b1;
    send_frame(8'h35, 7, 1'b1, 1'b1, 1'b1);
    idle(8);
    chk("7e1_p1_dout", 32'(DOUT), 32'h35);
    chk("7e1_p1_pe", 32'(PE), 32'd1);
    chk("7e1_p1_fe", 32'(FE), 32'd0);
    send_frame(8'h35, 7, 1'b1, 1'b0, 1'b1);
    idle(8);
    chk("7e1_p0_dout", 32'(DOUT), 32'h35);
    chk("7e1_p0_pe", 32'(PE), 32'd0);

    // 8O1 0x01: odd parity wants parity bit 0
    WLS = 2'b11; EPS = 1'b0;
    send_frame(8'h01, 8, 1'b1, 1'b0, 1'b1);
    idle(8);
    chk("8o1_p0_pe", 32'(PE), 32'd0);
    send_frame(8'h01, 8, 1'b1, 1'b1, 1'b1);
    idle(8);
    chk("8o1_p1_pe", 32'(PE), 32'd1);

    // Stick parity, 5 bits, EPS=0 -> parity bit must be 1
    WLS = 2'b00; PEN = 1'b1; SP = 1'b1; EPS = 1'b0;
    send_frame(8'h1F, 5, 1'b1, 1'b1, 1'b1);
    idle(8);
    chk("stk_p1_dout", 32'(DOUT), 32'h1F);
    chk("stk_p1_pe", 32'(PE), 32'd0);
    send_frame(8'h1F, 5, 1'b1, 1'b0, 1'b1);
    idle(8);
    chk("stk_p0_dout", 32'(DOUT), 32'h1F);
    chk("stk_p0_pe", 32'(PE), 32'd1);

    // Break: line low for three 8N1 frame times
    WLS = 2'b11; PEN = 1'b0; SP = 1'b0;
    f0 = fin_count;
    RXD = 1'b0;
    repeat (3 * 10 * OSR) @(posedge CLK);
    #1;
    chk("brk_fin", 32'(fin_count - f0), 32'd1);
    chk("brk_dout", 32'(DOUT), 32'h00);
    chk("brk_fe", 32'(FE), 32'd1);
    chk("brk_bi", 32'(BI), 32'd1);
    idle(32);
    send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b1);
    idle(8);
    chk("brk_next_fin", 32'(fin_count - f0), 32'd2);
    chk("brk_next_dout", 32'(DOUT), 32'h3C);
    chk("brk_next_flags", 32'({PE, FE, BI}), 32'h0);

    // Glitch: four pulses low is not a start bit
    f0 = fin_count;
    RXD = 1'b0;
    repeat (4) @(posedge CLK);
    #1;
    idle(40);
    chk("glitch_fin", 32'(fin_count - f0), 32'd0);
    send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b1);
    idle(8);
    chk("glitch_next_fin", 32'(fin_count - f0), 32'd1);
    chk("glitch_next_dout", 32'(DOUT), 32'h5A);

    // CLEAR during data bit 3
    f0 = fin_count;
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b1);
    drive_bit(1'b0);
    RXD = 1'b0;
    repeat (8) @(posedge CLK);
    #1;
    CLEAR = 1'b1;
    RXD = 1'b1;
    @(posedge CLK);
    #1;
    CLEAR = 1'b0;
    idle(200);
    chk("clr_fin", 32'(fin_count - f0), 32'd0);
    chk("clr_dout", 32'(DOUT), 32'h5A);
    send_frame(8'hC3, 8, 1'b0, 1'b0, 1'b1);
    idle(8);
    chk("clr_next_dout", 32'(DOUT), 32'hC3);
    chk("clr_next_flags", 32'({PE, FE, BI}), 32'h0);

    // RST during data bit 3
    f0 = fin_count;
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b1);
    drive_bit(1'b0);
    RXD = 1'b0;
    repeat (8) @(posedge CLK);
    #1;
    RST = 1'b1;
    RXD = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    idle(200);
    chk("rstab_fin", 32'(fin_count - f0), 32'd0);
    chk("rstab_dout", 32'(DOUT), 32'h00);
    send_frame(8'hC3, 8, 1'b0, 1'b0, 1'b1);
    idle(8);
    chk("rstab_next_dout", 32'(DOUT), 32'hC3);
    chk("rstab_next_flags", 32'({PE, FE, BI}), 32'h0);

    // Format changed right after the start bit is validated must not affect the frame
    drive_bit(1'b0);
    WLS = 2'b00; PEN = 1'b1;
    for (int i = 0; i < 8; i++) drive_bit(i[0] ? 1'b1 : 1'b0);
    drive_bit(1'b1);
    idle(8);
    chk("cfg_dout", 32'(DOUT), 32'hAA);
    chk("cfg_flags", 32'({PE, FE, BI}), 32'h0);
    WLS = 2'b11; PEN = 1'b0;

    // Sparse strobe: RXCLK every second cycle
    rxdiv = 2;
    f0 = fin_count;
    send_frame(8'h96, 8, 1'b0, 1'b0, 1'b1);
    idle(16);
    rxdiv = 1;
    chk("div2_fin", 32'(fin_count - f0), 32'd1);
    chk("div2_dout", 32'(DOUT), 32'h96);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
